lsu_mem_master: RTL and testbench

//  CPU-side initiator for the unified memory data port (W_en/R_en/ram_addr/RW_type/din/dout).

---
 rtl/lsu_mem_master_pkg.sv | 21 ++
 rtl/lsu_mem_master_load_extend.sv | 20 ++
 rtl/lsu_mem_master.sv | 102 ++++++++++
 tb/tb_lsu_mem_master.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_master_pkg.sv
// lsu_mem_master_pkg: shared access-type encodings, FSM states and alignment helper
package lsu_mem_master_pkg;

    localparam logic [1:0] RW_B        = 2'b00;
    localparam logic [1:0] RW_H        = 2'b01;
    localparam logic [1:0] RW_W        = 2'b10;
    localparam logic [1:0] RW_ILL      = 2'b11;
    localparam int         RW_UNSIGNED = 2;
    localparam logic [2:0] RW_UBYTE    = 3'b100;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lsb);
        return (size == RW_H && lsb[0]) || (size == RW_W && lsb != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_mem_master_load_extend.sv
// lsu_load_extend: sign/zero extension of an assembled load value by access size
module lsu_load_extend
    import lsu_mem_master_pkg::*;
(
    input  logic [31:0] acc,
    input  logic [2:0]  rw_type,
    output logic [31:0] rdata
);

    logic sx;

    // extend from bit 7 (B) or bit 15 (H) unless unsigned; words pass through
    always_comb begin
        sx    = ~rw_type[RW_UNSIGNED];
        rdata = rw_type[1:0] == RW_B ? {{24{sx & acc[7]}}, acc[7:0]}
              : rw_type[1:0] == RW_H ? {{16{sx & acc[15]}}, acc[15:0]}
              : acc;
    end

endmodule

// File: rtl/lsu_mem_master.sv
// lsu_mem_master: MEM-stage load/store initiator, splits misaligned accesses into byte beats
module lsu_mem_master
    import lsu_mem_master_pkg::*;
#(
    parameter bit SPLIT_MISALIGNED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        mem_W_en,
    output logic        mem_R_en,
    output logic [31:0] mem_addr,
    output logic [2:0]  mem_RW_type,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    state_t      state, state_nx;
    logic [31:0] addr_q, wdata_q, acc_q, ext_rdata;
    logic [2:0]  type_q;
    logic        we_q, split_q, err_q, issue;
    logic [1:0]  k_q, last_q;
    logic        misal, bad;

    assign misal = is_misaligned(req_type[1:0], req_addr[1:0]);
    assign bad   = req_type[1:0] == RW_ILL || (misal && !SPLIT_MISALIGNED);

    lsu_load_extend u_ext (
        .acc     (acc_q),
        .rw_type (type_q),
        .rdata   (ext_rdata)
    );

    // state register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    // errors skip the beat phase; ISSUE runs until the last beat index
    always_comb begin
        state_nx = state == IDLE  ? (req_valid ? (bad ? RESP : ISSUE) : IDLE)
                 : state == ISSUE ? (k_q == last_q ? RESP : ISSUE)
                 : IDLE;
    end

    // request capture at handshake, beat counting and load byte assembly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            acc_q   <= '0;
            type_q  <= '0;
            we_q    <= 1'b0;
            split_q <= 1'b0;
            err_q   <= 1'b0;
            k_q     <= '0;
            last_q  <= '0;
        end else if (state == IDLE && req_valid) begin
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            acc_q   <= '0;
            type_q  <= req_type;
            we_q    <= req_we;
            split_q <= misal;
            err_q   <= bad;
            k_q     <= '0;
            last_q  <= (misal && !bad) ? (req_type[1:0] == RW_H ? 2'd1 : 2'd3) : 2'd0;
        end else if (state == ISSUE) begin
            k_q <= k_q + 2'd1;
            if (split_q)
                acc_q[{k_q, 3'b000} +: 8] <= mem_dout[7:0];
            else
                acc_q <= mem_dout;
        end
    end

    // memory port is live only in ISSUE; response fields only in RESP
    always_comb begin
        issue       = state == ISSUE;
        req_ready   = state == IDLE;
        mem_W_en    = issue && we_q;
        mem_R_en    = issue && !we_q;
        mem_addr    = !issue ? 32'd0 : split_q ? addr_q + {30'd0, k_q} : addr_q;
        mem_RW_type = !issue ? 3'd0 : split_q ? RW_UBYTE : type_q;
        mem_din     = !issue ? 32'd0 : split_q ? {24'd0, wdata_q[{k_q, 3'b000} +: 8]} : wdata_q;
        rsp_valid   = state == RESP;
        rsp_err     = rsp_valid && err_q;
        rsp_rdata   = (!rsp_valid || err_q || we_q) ? 32'd0 : split_q ? ext_rdata : acc_q;
    end

endmodule

// File: tb/tb_lsu_mem_master.sv
// tb_lsu_mem_master: randomized and directed checks against a byte-array reference model
module tb_lsu_mem_master;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_type;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_W_en, mem_R_en;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic [2:0]  mem_RW_type;

    logic        ns_ready, ns_rsp_valid, ns_err, ns_W_en, ns_R_en;
    logic [31:0] ns_rdata, ns_addr, ns_din;
    logic [2:0]  ns_type;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lsu_mem_master #(.SPLIT_MISALIGNED(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_W_en(mem_W_en), .mem_R_en(mem_R_en), .mem_addr(mem_addr),
        .mem_RW_type(mem_RW_type), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    lsu_mem_master #(.SPLIT_MISALIGNED(1'b0)) u_ns (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(ns_ready), .req_we(req_we),
        .req_addr(req_addr), .req_type(req_type), .req_wdata(req_wdata),
        .rsp_valid(ns_rsp_valid), .rsp_rdata(ns_rdata), .rsp_err(ns_err),
        .mem_W_en(ns_W_en), .mem_R_en(ns_R_en), .mem_addr(ns_addr),
        .mem_RW_type(ns_type), .mem_din(ns_din), .mem_dout(32'd0)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 151) ^ 90);
    endfunction

    // memory environment: 1 KiB byte array, combinational read, write gated by rst_n
    logic [7:0] mem [1024];
    logic [7:0] ref_mem [1024];
    logic       prime = 1'b1;
    logic [9:0] ia;

    always_comb begin
        ia = mem_addr[9:0];
        if (mem_RW_type[1:0] == 2'b00)
            mem_dout = {{24{~mem_RW_type[2] & mem[ia][7]}}, mem[ia]};
        else if (mem_RW_type[1:0] == 2'b01)
            mem_dout = {{16{~mem_RW_type[2] & mem[ia + 10'd1][7]}}, mem[ia + 10'd1], mem[ia]};
        else
            mem_dout = {mem[ia + 10'd3], mem[ia + 10'd2], mem[ia + 10'd1], mem[ia]};
    end

    always @(posedge clk) begin
        if (prime) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pat(i);
        end else if (rst_n && mem_W_en) begin
            mem[ia] <= mem_din[7:0];
            if (mem_RW_type[1:0] != 2'b00) mem[ia + 10'd1] <= mem_din[15:8];
            if (mem_RW_type[1:0] == 2'b10) begin
                mem[ia + 10'd2] <= mem_din[23:16];
                mem[ia + 10'd3] <= mem_din[31:24];
            end
        end
    end

    // one full transaction; called at a negedge with the DUT idle
    task automatic do_req(input logic we, input logic [31:0] a, input logic [2:0] t,
                          input logic [31:0] wd, output logic [31:0] got);
        int sz, n, nns;
        bit mis, err, errns;
        logic [31:0] v, exp;
        sz    = t[1:0] == 2'b00 ? 1 : t[1:0] == 2'b01 ? 2 : 4;
        err   = t[1:0] == 2'b11;
        mis   = !err && ((a & 32'(sz - 1)) != 0);
        errns = err || mis;
        n     = err ? 0 : mis ? sz : 1;
        nns   = errns ? 0 : 1;
        v = 0;
        for (int i = 0; i < sz; i++) v |= 32'(ref_mem[10'(a + 32'(i))]) << (8 * i);
        if (!t[2] && sz == 1) v = {{24{v[7]}}, v[7:0]};
        else if (!t[2] && sz == 2) v = {{16{v[15]}}, v[15:0]};
        exp = (err || we) ? 32'd0 : v;
        got = 0;
        check("idle_ready", req_ready, 1);
        req_valid = 1; req_we = we; req_addr = a; req_type = t; req_wdata = wd;
        @(negedge clk);
        for (int c = 1; c <= n + 1; c++) begin
            req_valid = (c <= n && c <= 1 + nns) ? 1'($urandom_range(0, 1)) : 1'b0;
            req_we = 1'($urandom); req_addr = $urandom; req_type = 3'($urandom); req_wdata = $urandom;
            if (c <= n) begin
                check("beat_addr", mem_addr, mis ? a + 32'(c - 1) : a);
                check("beat_type", mem_RW_type, mis ? 3'b100 : t);
                check("beat_wen", mem_W_en, we);
                check("beat_ren", mem_R_en, !we);
                check("beat_ready", req_ready, 0);
                if (we) check("beat_din", mis ? {24'd0, mem_din[7:0]} : mem_din,
                              mis ? (wd >> (8 * (c - 1))) & 32'hFF : wd);
                check("beat_no_rsp", rsp_valid, 0);
            end else begin
                check("rsp_valid", rsp_valid, 1);
                check("rsp_err", rsp_err, err);
                check("rsp_rdata", rsp_rdata, exp);
                check("rsp_mem_idle", {mem_W_en, mem_R_en}, 0);
                check("rsp_ready", req_ready, 0);
                got = rsp_rdata;
            end
            check("ns_valid", ns_rsp_valid, c == 1 + nns);
            if (c == 1 + nns) check("ns_err", ns_err, errns);
            @(negedge clk);
        end
        if (we && !err)
            for (int i = 0; i < sz; i++) ref_mem[10'(a + 32'(i))] = wd[8 * i +: 8];
        check("rsp_pulse_end", rsp_valid, 0);
    endtask

    logic [31:0] r;
    int rt;

    initial begin
        for (int i = 0; i < 1024; i++) ref_mem[i] = pat(i);
        req_valid = 0; req_we = 0; req_addr = 0; req_type = 0; req_wdata = 0;
        repeat (3) @(negedge clk);
        prime = 1'b0;
        check("rst_ready", req_ready, 1);
        check("rst_rsp", {rsp_valid, rsp_err}, 0);
        check("rst_rdata", rsp_rdata, 0);
        check("rst_en", {mem_W_en, mem_R_en}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_type", mem_RW_type, 0);
        check("rst_din", mem_din, 0);
        rst_n = 1;
        @(negedge clk);

        do_req(1, 32'h100, 3'b010, 32'hDEADBEEF, r);
        do_req(0, 32'h100, 3'b010, 0, r);
        check("t1_lw", r, 32'hDEADBEEF);
        do_req(1, 32'h101, 3'b000, 32'h80, r);
        do_req(0, 32'h101, 3'b000, 0, r);
        check("t2_lb", r, 32'hFFFFFF80);
        do_req(0, 32'h101, 3'b100, 0, r);
        check("t2_lbu", r, 32'h00000080);
        do_req(1, 32'h203, 3'b010, 32'h11223344, r);
        do_req(0, 32'h200, 3'b010, 0, r);
        check("t3_lw_top", r[31:24], 8'h44);
        do_req(1, 32'h3, 3'b000, 32'hFE, r);
        do_req(1, 32'h4, 3'b000, 32'hFF, r);
        do_req(0, 32'h3, 3'b001, 0, r);
        check("t4_lh", r, 32'hFFFFFFFE);
        do_req(0, 32'h3, 3'b101, 0, r);
        check("t4_lhu", r, 32'h0000FFFE);
        do_req(0, 32'hFFFFFFFE, 3'b010, 0, r);
        do_req(0, 32'h40, 3'b011, 0, r);

        do_req(1, 32'h204, 3'b010, 0, r);
        do_req(1, 32'h203, 3'b000, 0, r);
        req_valid = 1; req_we = 1; req_addr = 32'h203; req_type = 3'b010; req_wdata = 32'h11223344;
        @(negedge clk);
        req_valid = 0;
        check("t6_b0_addr", mem_addr, 32'h203);
        @(negedge clk);
        check("t6_b1_addr", mem_addr, 32'h204);
        rst_n = 0;
        @(negedge clk);
        check("t6_ready", req_ready, 1);
        check("t6_en", {mem_W_en, mem_R_en, rsp_valid, rsp_err}, 0);
        check("t6_addr", mem_addr, 0);
        check("t6_din", mem_din, 0);
        ref_mem[10'h203] = 8'h44;
        rst_n = 1;
        @(negedge clk);
        do_req(0, 32'h203, 3'b100, 0, r);
        check("t6_byte0", r, 32'h44);
        do_req(0, 32'h204, 3'b010, 0, r);
        check("t6_rest", r, 32'h0);

        for (int i = 0; i < 300; i++) begin
            rt = $urandom_range(0, 9);
            do_req(1'($urandom),
                   $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 1023)),
                   {1'($urandom), rt == 9 ? 2'b11 : 2'(rt % 3)},
                   $urandom, r);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
